// File: rtl/prio_arbiter_8_if.sv
// rtl/prio_arbiter_8_if.sv - requester-bank / arbiter bundle for the 8-way arbiter
interface prio_arbiter_8_if;
    logic       mode;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    // Requester side: drives requests and mode, observes the grant.
    modport master (
        output mode,
        output req,
        input  grant,
        input  grant_id,
        input  grant_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  mode,
        input  req,
        output grant,
        output grant_id,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/prio_arbiter_8.sv
// rtl/prio_arbiter_8.sv - 8-requester fixed/round-robin arbiter with hold timeout and turnaround
module prio_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    prio_arbiter_8_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    // A zero MAX_HOLD means the owner may hold the resource indefinitely.
    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);

    state_t     state_q;
    logic [7:0] grant_q;
    logic [2:0] grant_id_q;
    logic       grant_valid_q;
    logic       timeout_q;
    logic [2:0] last_id_q;
    logic [7:0] mask_q;
    logic [7:0] hold_cnt_q;

    logic [7:0] elig;
    logic [2:0] win_id;
    logic       win_found;
    logic [2:0] rr_start;
    logic [2:0] rr_idx;

    // A requester just preempted by timeout sits out exactly one decision.
    assign elig = bus.req & ~mask_q;

    // Winner selection: highest index in fixed mode, descending search
    // starting just below the previous winner in round-robin mode.
    always_comb begin
        win_id    = 3'd0;
        win_found = 1'b0;
        rr_start  = last_id_q - 3'd1;
        rr_idx    = 3'd0;
        if (!bus.mode) begin
            for (int i = 0; i < 8; i++) begin
                if (elig[i]) begin
                    win_id = i[2:0];
                end
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                rr_idx = rr_start - k[2:0];
                if (!win_found && elig[rr_idx]) begin
                    win_id    = rr_idx;
                    win_found = 1'b1;
                end
            end
        end
    end

    // Arbitration FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_q       <= 8'd0;
            grant_id_q    <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            last_id_q     <= 3'd0;
            mask_q        <= 8'd0;
            hold_cnt_q    <= 8'd0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (elig != 8'd0) begin
                        grant_q       <= 8'd1 << win_id;
                        grant_id_q    <= win_id;
                        grant_valid_q <= 1'b1;
                        hold_cnt_q    <= 8'd0;
                        mask_q        <= 8'd0;
                        last_id_q     <= win_id;
                        state_q       <= S_GRANT;
                    end else if (bus.req != 8'd0) begin
                        // Only the masked requester is asking: let it back in.
                        mask_q <= 8'd0;
                    end
                end
                S_GRANT: begin
                    if (hold_cnt_q != 8'hFF) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                    if (!bus.req[grant_id_q]) begin
                        // Voluntary release wins over a coincident timeout.
                        grant_q       <= 8'd0;
                        grant_id_q    <= 3'd0;
                        grant_valid_q <= 1'b0;
                        state_q       <= S_TURN;
                    end else if (TIMEOUT_EN && (hold_cnt_q == HOLD_LAST)) begin
                        grant_q       <= 8'd0;
                        grant_id_q    <= 3'd0;
                        grant_valid_q <= 1'b0;
                        timeout_q     <= 1'b1;
                        mask_q        <= 8'd1 << grant_id_q;
                        state_q       <= S_TURN;
                    end
                end
                S_TURN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.timeout     = timeout_q;

endmodule
